// File: rtl/ttm4_pkg.sv
// ttm4_pkg: shared opcodes, sequencer state encoding and bus source/destination types for the TTM4 core.
package ttm4_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {SRC_ZERO, SRC_A, SRC_B, SRC_IN} src_e;
    typedef enum logic [2:0] {DST_NONE, DST_A, DST_B, DST_OUT, DST_PC} dst_e;
endpackage

// File: rtl/ttm4_instr_decode.sv
// ttm4_instr_decode: combinational opcode (+carry for JNC) to LOADBUS source, store destination and carry-update flag.
module ttm4_instr_decode
    import ttm4_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       cflag,
    output src_e       src,
    output dst_e       dst,
    output logic       updates_c
);
    always_comb begin
        src       = SRC_ZERO;
        dst       = DST_NONE;
        updates_c = 1'b1;
        case (opcode)
            OP_ADD_A:  begin src = SRC_A;  dst = DST_A;   end
            OP_ADD_B:  begin src = SRC_B;  dst = DST_B;   end
            OP_MOV_AI: dst = DST_A;
            OP_MOV_BI: dst = DST_B;
            OP_MOV_AB: begin src = SRC_B;  dst = DST_A;   end
            OP_MOV_BA: begin src = SRC_A;  dst = DST_B;   end
            OP_IN_A:   begin src = SRC_IN; dst = DST_A;   end
            OP_IN_B:   begin src = SRC_IN; dst = DST_B;   end
            OP_OUT_B:  begin src = SRC_B;  dst = DST_OUT; end
            OP_OUT_I:  dst = DST_OUT;
            OP_JMP:    dst = DST_PC;
            OP_JNC:    dst = cflag ? DST_NONE : DST_PC;
            default:   updates_c = 1'b0;
        endcase
    end
endmodule

// File: rtl/ttm4_bus_sequencer.sv
// ttm4_bus_sequencer: TTM4 FETCH/EXEC/COMMIT sequencer driving LOADBUS enables and store strobes,
// with carry flag and free-run / single-step control. All bus controls are registered.
module ttm4_bus_sequencer
    import ttm4_pkg::*;
#(
    parameter bit STEP_ONLY_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    input  logic       alu_co,
    input  logic       run,
    input  logic       step,
    output logic [3:0] imm,
    output logic       na_out,
    output logic       nb_out,
    output logic       nin_out,
    output logic       na_st,
    output logic       nb_st,
    output logic       nout_st,
    output logic       npc_ld,
    output logic       pc_en,
    output logic       cflag,
    output logic       busy
);
    logic [1:0] state, next_state;
    logic [3:0] opcode, dec_op;
    logic       armed, go, upd_c;
    src_e       src, nxt_src;
    dst_e       dst, nxt_dst;

    // Source is decoded straight from INSTR during FETCH so it is on the bus from the first EXEC cycle.
    assign dec_op = (state == S_FETCH) ? instr[7:4] : opcode;
    assign go     = (run && armed) || step;
    assign busy   = state != S_IDLE;

    ttm4_instr_decode u_dec (
        .opcode    (dec_op),
        .cflag     (cflag),
        .src       (src),
        .dst       (dst),
        .updates_c (upd_c)
    );

    always_comb begin
        next_state = (state == S_IDLE)  ? (go ? S_FETCH : S_IDLE) :
                     (state == S_FETCH) ? S_EXEC :
                     (state == S_EXEC)  ? S_COMMIT :
                     (run ? S_FETCH : S_IDLE);
        nxt_src    = (state == S_FETCH || state == S_EXEC) ? src : SRC_ZERO;
        nxt_dst    = (state == S_EXEC) ? dst : DST_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            opcode  <= '0;
            imm     <= '0;
            cflag   <= 1'b0;
            armed   <= !STEP_ONLY_RESET;
            na_out  <= 1'b1;
            nb_out  <= 1'b1;
            nin_out <= 1'b1;
            na_st   <= 1'b1;
            nb_st   <= 1'b1;
            nout_st <= 1'b1;
            npc_ld  <= 1'b1;
            pc_en   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && step) armed <= 1'b1;
            if (state == S_FETCH) begin
                opcode <= instr[7:4];
                imm    <= instr[3:0];
            end
            if (state == S_COMMIT && upd_c) cflag <= alu_co;
            na_out  <= nxt_src != SRC_A;
            nb_out  <= nxt_src != SRC_B;
            nin_out <= nxt_src != SRC_IN;
            na_st   <= nxt_dst != DST_A;
            nb_st   <= nxt_dst != DST_B;
            nout_st <= nxt_dst != DST_OUT;
            npc_ld  <= nxt_dst != DST_PC;
            pc_en   <= state == S_EXEC && dst != DST_PC;
        end
    end
endmodule
